ladder_operand_loader: RTL
==========================

Name: ladder_operand_loader

Overview:
Front-end stage that feeds the Montgomery-ladder exponentiation core and consumes its result.
- Accepts X, M, E, R and R2 as 32-bit word streams and assembles each into a 1024-bit operand register.
- Computes the exponent bit length `lene` on the fly while E is loaded.
- Pulses the core's start and waits for its done pulse.
- Captures the 1024-bit result on the done cycle and streams it back out as 32 words.

Parameters:
- DATA_W, 32, stream word width.
- OP_W, 1024, operand width. Must be a multiple of DATA_W.
- WORDS, OP_W/DATA_W (32), beats per operand. Derived; do not override.

Ports:
- clk  in  1  clock; all logic on rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- s_valid  in  1  input word valid.
- s_ready  out  1  input word accepted when s_valid & s_ready.
- s_data  in  DATA_W  operand word, least-significant word first.
- s_sel  in  3  target operand: 0=X, 1=M, 2=E, 3=R, 4=R2. Values 5-7 are illegal.
- go  in  1  single-cycle request to run an exponentiation.
- busy  out  1  high from accepted go until the last result beat is accepted.
- err  out  1  sticky protocol/operand error; cleared by the next accepted go.
- lx, lm, le, lr, lr2  out  OP_W each  operand registers to the core (in_x, in_m, in_e, in_r, in_r2).
- lene  out  32  bit length of E, zero-extended; drives the core's lene.
- core_start  out  1  one-cycle start pulse to the core.
- core_done  in  1  one-cycle done pulse from the core.
- core_result  in  OP_W  core result. Valid only in the core_done cycle.
- m_valid  out  1  result word valid.
- m_ready  in  1  downstream accepts result word.
- m_data  out  DATA_W  result word, least-significant first.
- m_last  out  1  high on the final (WORDS-th) result beat.

Behaviour:
- Reset (async, resetn=0) forces:
  - state LOAD; s_ready=1; busy=0; err=0; core_start=0; m_valid=0; m_last=0; m_data=0.
  - lene=0; all five loaded flags=0; beat counter=0.
  - Operand registers are not reset. Reset mid-run abandons the run; the core shares resetn.
- States: LOAD -> START -> WAIT -> DRAIN -> LOAD.
- LOAD:
  - s_ready=1 only in this state.
  - Accepted beat: target register <= {s_data, reg[OP_W-1:DATA_W]}; beat counter increments.
  - On the WORDS-th beat: counter wraps to 0 and loaded[s_sel] is set.
  - If s_sel differs from the previous beat's s_sel while counter!=0: err=1, counter restarts at this beat as beat 0 of the new operand.
  - Illegal s_sel (5-7): beat is accepted and discarded, err=1.
  - E loading, beat index k:
    - At k=0, lene is cleared before evaluation.
    - If s_data!=0: lene <= DATA_W*k + (index of highest set bit of s_data)+1.
    - Zero words leave lene unchanged, so after the full load lene is the bit length of E (1..1024).
  - Partial reload of an operand does not clear its loaded flag; the register holds the mixed value (software responsibility).
- go in LOAD:
  - Accepted only if all five loaded flags are set, lene!=0, and no beat is in progress (counter=0).
  - Accepted: err <= 0, go to START.
  - Rejected: err <= 1, stay in LOAD. This matters because E=0 would hang the core.
  - go outside LOAD is ignored. go coincident with an accepted beat: the beat takes effect first, then go is evaluated on the next cycle only if still asserted.
- START: core_start=1 for exactly one cycle; busy=1; next state WAIT.
- WAIT:
  - In the core_done cycle, capture core_result into the internal result register.
  - Capture is mandatory: core_result changes the cycle after done. Go to DRAIN.
  - No timeout.
- DRAIN:
  - m_valid=1; m_data = result_reg[DATA_W-1:0]; m_last = (beat counter == WORDS-1).
  - On m_valid & m_ready: result_reg >>= DATA_W; counter increments.
  - m_data/m_last hold stable while m_ready=0.
  - After the last beat handshakes: counter=0, m_valid=0, busy=0, return to LOAD.
- Operands and loaded flags persist across runs, so only changed operands need reloading.
- lx..lr2 and lene must not change outside LOAD.

Test Plan:
1. Load X=5, M=0xF7 (padded to 1024 bits), E=0x10001, R, R2 -> lene=17, all flags set. Accepted go -> one core_start pulse, busy=1, s_ready=0.
2. Load E with only word 31 = 0x80000000 -> lene=1024. Load E = all-zero -> go rejected, err=1, no core_start, state stays LOAD.
3. Core model pulses core_done with result 0x1234...ABCD and changes core_result to 0 on the next cycle -> streamed words reproduce 0x1234...ABCD, LS word first, m_last on beat 32 only.
4. Drain with m_ready toggling 1,0,0,1 -> no word dropped or duplicated; m_data stable during stalls; busy falls after the 32nd handshake.
5. Switch s_sel from X to M after 10 beats -> err=1, X flag not set, M counts from that beat. Next accepted go clears err.
6. Assert resetn=0 asynchronously mid-DRAIN (beat 12) -> m_valid=0 and busy=0 immediately; flags cleared; go after reset is rejected until all operands are reloaded.

Source files
------------

// File: rtl/ladder_operand_loader.sv
// Operand loader / result drainer in front of the Montgomery-ladder exponentiation core.
// Streams X, M, E, R, R2 in as DATA_W words, tracks E's bit length, runs the core and streams the result out.
module ladder_operand_loader #(
  parameter  int DATA_W = 32,
  parameter  int OP_W   = 1024,
  localparam int WORDS  = OP_W / DATA_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic [2:0]        s_sel,
  input  logic              go,
  output logic              busy,
  output logic              err,
  output logic [OP_W-1:0]   lx,
  output logic [OP_W-1:0]   lm,
  output logic [OP_W-1:0]   le,
  output logic [OP_W-1:0]   lr,
  output logic [OP_W-1:0]   lr2,
  output logic [31:0]       lene,
  output logic              core_start,
  input  logic              core_done,
  input  logic [OP_W-1:0]   core_result,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  localparam int CNT_W = $clog2(WORDS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(WORDS - 1);

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       sel_q, sel_d;
  logic [4:0]       loaded_q, loaded_d;
  logic             err_q, err_d;
  logic [31:0]      lene_q, lene_d;
  logic [OP_W-1:0]  x_q, x_d, m_q, m_d, e_q, e_d, r_q, r_d, r2_q, r2_d;
  logic [OP_W-1:0]  res_q, res_d;

  logic [CNT_W-1:0] beat_idx;
  logic [31:0]      word_len;

  // Bit length of a single word: index of highest set bit plus one, zero for an all-zero word.
  function automatic logic [31:0] word_bit_len(input logic [DATA_W-1:0] w);
    logic [31:0] len;
    len = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (w[i]) len = 32'(i + 1);
    end
    return len;
  endfunction

  assign word_len = word_bit_len(s_data);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    loaded_d = loaded_q;
    err_d    = err_q;
    lene_d   = lene_q;
    x_d      = x_q;
    m_d      = m_q;
    e_d      = e_q;
    r_d      = r_q;
    r2_d     = r2_q;
    res_d    = res_q;
    beat_idx = cnt_q;

    case (state_q)
      ST_LOAD: begin
        if (s_valid) begin
          if (s_sel > 3'd4) begin
            err_d = 1'b1;
          end else begin
            // A selector change mid-operand abandons the old operand and restarts counting here.
            if ((cnt_q != '0) && (s_sel != sel_q)) begin
              err_d    = 1'b1;
              beat_idx = '0;
            end
            case (s_sel)
              3'd0:    x_d  = {s_data, x_q[OP_W-1:DATA_W]};
              3'd1:    m_d  = {s_data, m_q[OP_W-1:DATA_W]};
              3'd2:    e_d  = {s_data, e_q[OP_W-1:DATA_W]};
              3'd3:    r_d  = {s_data, r_q[OP_W-1:DATA_W]};
              default: r2_d = {s_data, r2_q[OP_W-1:DATA_W]};
            endcase
            if (s_sel == 3'd2) begin
              if (beat_idx == '0) lene_d = '0;
              if (word_len != '0) lene_d = 32'(DATA_W) * 32'(beat_idx) + word_len;
            end
            if (beat_idx == LAST_BEAT) begin
              cnt_d           = '0;
              loaded_d[s_sel] = 1'b1;
            end else begin
              cnt_d = beat_idx + CNT_W'(1);
            end
            sel_d = s_sel;
          end
        end else if (go) begin
          // Refuse to start with missing operands, a half-loaded operand, or E=0 (the core would hang).
          if ((&loaded_q) && (lene_q != '0) && (cnt_q == '0)) begin
            err_d   = 1'b0;
            state_d = ST_START;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (core_done) begin
          res_d   = core_result;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (m_ready) begin
          res_d = res_q >> DATA_W;
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = ST_LOAD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_LOAD;
      cnt_q    <= '0;
      sel_q    <= '0;
      loaded_q <= '0;
      err_q    <= 1'b0;
      lene_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      loaded_q <= loaded_d;
      err_q    <= err_d;
      lene_q   <= lene_d;
    end
  end

  // Wide datapath registers carry no reset; software reloads them after a reset.
  always_ff @(posedge clk) begin
    x_q   <= x_d;
    m_q   <= m_d;
    e_q   <= e_d;
    r_q   <= r_d;
    r2_q  <= r2_d;
    res_q <= res_d;
  end

  assign s_ready    = (state_q == ST_LOAD);
  assign busy       = (state_q != ST_LOAD);
  assign err        = err_q;
  assign core_start = (state_q == ST_START);
  assign m_valid    = (state_q == ST_DRAIN);
  assign m_data     = (state_q == ST_DRAIN) ? res_q[DATA_W-1:0] : '0;
  assign m_last     = (state_q == ST_DRAIN) && (cnt_q == LAST_BEAT);
  assign lene       = lene_q;
  assign lx         = x_q;
  assign lm         = m_q;
  assign le         = e_q;
  assign lr         = r_q;
  assign lr2        = r2_q;

endmodule
